// File: rtl/alu_shift_add_multiplier.sv
// Shift-and-add unsigned multiplier that borrows an external ALU as its adder.
// One ADD per RUN cycle; the carry is shifted back into the accumulator every step.
module alu_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  output logic [2:0]           alu_command,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_zero
);

  localparam int COUNT_W = $clog2(WIDTH) + 1;
  localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sRun  = 2'd1,
    sDone = 2'd2
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [WIDTH-1:0]     accHi;
  logic [WIDTH-1:0]     accLo;
  logic [WIDTH-1:0]     mcand;
  logic [COUNT_W-1:0]   count;
  logic                 startReadyReg;
  logic                 doneValidReg;
  logic [2*WIDTH-1:0]   productReg;
  logic                 productZeroReg;
  logic                 accept;

  assign accept = start_valid && startReadyReg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      sIdle: if (accept) stateNext = sRun;
      sRun:  if (count == LAST_STEP) stateNext = sDone;
      sDone: if (doneValidReg && done_ready) stateNext = sIdle;
      default: stateNext = sIdle;
    endcase
  end

  // ALU drive: only RUN presents a real addition, otherwise the adder idles at 0 + 0
  always_comb begin
    alu_operandA = '0;
    alu_operandB = '0;
    if (state == sRun) begin
      alu_operandA = accHi;
      alu_operandB = accLo[0] ? mcand : '0;
    end
  end

  assign alu_command = 3'd0;

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      accHi          <= '0;
      accLo          <= '0;
      mcand          <= '0;
      count          <= '0;
      startReadyReg  <= 1'b1;
      doneValidReg   <= 1'b0;
      productReg     <= '0;
      productZeroReg <= 1'b0;
    end else begin
      startReadyReg <= (stateNext == sIdle);
      case (state)
        sIdle: begin
          if (accept) begin
            mcand <= multiplicand;
            accLo <= multiplier;
            accHi <= '0;
            count <= '0;
          end
        end
        sRun: begin
          {accHi, accLo} <= {alu_carryout, alu_result, accLo[WIDTH-1:1]};
          count          <= count + 1'b1;
        end
        sDone: begin
          // First DONE cycle publishes the accumulator; later cycles just hold it
          if (!doneValidReg) begin
            productReg     <= {accHi, accLo};
            productZeroReg <= ({accHi, accLo} == '0);
            doneValidReg   <= 1'b1;
          end else if (done_ready) begin
            doneValidReg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = startReadyReg;
  assign done_valid   = doneValidReg;
  assign product      = productReg;
  assign product_zero = productZeroReg;

endmodule
